dmem_responder: RTL and testbench

Memory-side responder for the pipelined CPU's data-memory port. It accepts one load/store request at a time over a req/ready handshake, holds it for a fixed programmable latency, commits or reads a word-addressed storage array, and returns a one-cycle acknowledge with read data. It lets the CPU's MEM stage stall on slow memory, and it lets the verification bench model realistic memory latency.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_array.sv | 37 +++
 rtl/dmem_responder.sv | 153 +++++++++++++++
 tb/tb_dmem_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dmem_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Byte address to full-width word index; callers keep the low bits they need.
  function automatic logic [WORD_W-1:0] word_index(input logic [WORD_W-1:0] addr);
    return addr >> BYTE_OFF_W;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 storage with synchronous write and registered synchronous read.
// Latency: read data appears the edge after rd_en; write lands on the wr_en edge.
// Backpressure: none; driven by the responder only on its commit edge.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= wdata;
    end
  end

  // Read register holds the last loaded word until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed LATENCY, one-cycle ack with read data.
// Latency: ack_o exactly LATENCY cycles after acceptance; optional DMEM_ALIGN_CHECK_EN flags bad addresses.
// Backpressure: ready_o low while a request is waiting; req_i must be held until accepted.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic              ready_o,
  output logic              ack_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;
  // With a single-cycle latency the commit edge is also the acceptance edge,
  // so the commit must use the live inputs rather than the holding registers.
  localparam bit DIRECT = (LATENCY == 1);
  localparam logic [WORD_W:0] ADDR_LIMIT = (WORD_W+1)'(DEPTH_WORDS) << BYTE_OFF_W;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;
  logic               we_q;
  logic [WORD_W-1:0]  addr_q, wdata_q;
  logic               c_we;
  logic [WORD_W-1:0]  c_addr, c_wdata;
  logic [WORD_W-1:0]  widx;
  logic [IDX_W-1:0]   idx;
  logic               commit;
  logic               bad;
  logic               mem_we, mem_re;
  logic               unused_addr_bits;

  assign ready_o = (state_q != ST_WAIT);
  assign ack_o   = (state_q == ST_RESP);
  assign accept  = req_i && ready_o;

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          if (DIRECT) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Holding registers capture the request on acceptance.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= we_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
    end
  end

  assign c_we    = DIRECT ? we_i    : we_q;
  assign c_addr  = DIRECT ? addr_i  : addr_q;
  assign c_wdata = DIRECT ? wdata_i : wdata_q;

  // Every entry into RESP is a commit edge.
  assign commit = (state_d == ST_RESP);
  assign widx   = word_index(c_addr);
  assign idx    = widx[IDX_W-1:0];

`ifdef DMEM_ALIGN_CHECK_EN
  assign bad = (c_addr[BYTE_OFF_W-1:0] != '0) || ({1'b0, c_addr} >= ADDR_LIMIT);
`else
  assign bad = 1'b0;
`endif

  // Byte offset and upper bits only matter to the optional range check.
  assign unused_addr_bits = ^{widx[WORD_W-1:IDX_W], c_addr[BYTE_OFF_W-1:0], ADDR_LIMIT};

  assign mem_we = commit &&  c_we && !bad;
  assign mem_re = commit && !c_we && !bad;

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q;

  // Error flag is captured on the commit edge and lives only for the RESP cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= commit && bad;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk_i),
    .rst_n (rst_i),
    .wr_en (mem_we),
    .rd_en (mem_re),
    .idx   (idx),
    .wdata (c_wdata),
    .rdata (rdata_o)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=3 and a LATENCY=1 instance against a word-array model.
// Latency: checks the exact ack cycle for every request.
// Backpressure: holds req while ready is low and checks such requests are ignored.
module tb_dmem_responder;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_n;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        ready [2];
  logic        ack   [2];
  logic [31:0] rdata [2];
  logic        err   [2];

  logic [31:0] mem_m [2][DEPTH];
  logic [31:0] rd_m  [2];

  int errors = 0;
  int checks = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u_lat3 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .ready_o(ready[0]), .ack_o(ack[0]), .rdata_o(rdata[0]), .err_o(err[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_lat1 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .ready_o(ready[1]), .ack_o(ack[1]), .rdata_o(rdata[1]), .err_o(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_bad(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return (a % 4 != 0) || (a >= 4 * DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated request on DUT d, checked for latency, ready, ack width, data and error.
  task automatic single_txn(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd);
    int lat;
    int n;
    bit bad;
    lat = (d == 0) ? 3 : 1;
    bad = is_bad(a);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    n = 0;
    while (ready[d] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL accept_timeout dut%0d: ready=%b want 1", d, ready[d]);
    end
    tick();
    req[d] = 1'b0; we[d] = 1'($urandom); addr[d] = $urandom; wdata[d] = $urandom;
    n = 1;
    while (ack[d] !== 1'b1 && n < 20) begin
      if (d == 0) begin
        checks++;
        if (ready[d] !== 1'b0) begin
          errors++;
          $display("FAIL ready_in_wait dut%0d cycle %0d: got %b want 0", d, n, ready[d]);
        end
      end
      tick();
      n++;
    end
    checks++;
    if (n != lat) begin
      errors++;
      $display("FAIL latency dut%0d addr %h: got %0d want %0d", d, a, n, lat);
    end
    if (!bad) begin
      if (w) mem_m[d][widx(a)] = wd;
      else   rd_m[d] = mem_m[d][widx(a)];
    end
    checks++;
    if (err[d] !== bad) begin
      errors++;
      $display("FAIL err dut%0d addr %h: got %b want %b", d, a, err[d], bad);
    end
    checks++;
    if (rdata[d] !== rd_m[d]) begin
      errors++;
      $display("FAIL rdata dut%0d addr %h: got %h want %h", d, a, rdata[d], rd_m[d]);
    end
    tick();
    checks++;
    if (ack[d] !== 1'b0) begin
      errors++;
      $display("FAIL ack_single dut%0d: got %b want 0", d, ack[d]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      rd_m[i] = '0;
      checks++;
      if (ready[i] !== 1'b1 || ack[i] !== 1'b0 || rdata[i] !== 32'h0 || err[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got rdy=%b ack=%b rd=%h err=%b want 1 0 0 0",
                 i, ready[i], ack[i], rdata[i], err[i]);
      end
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (ack[i] !== 1'b0 || ready[i] !== 1'b1) begin
          errors++;
          $display("FAIL idle dut%0d cycle %0d: got ack=%b rdy=%b want 0 1", i, c, ack[i], ready[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < DEPTH; k++)
        single_txn(i, 1'b1, 32'(k * 4), $urandom);
  endtask

  // Store then a load held through WAIT; the load is taken in the store's ack cycle.
  task automatic test_back_to_back();
    bit exp_ack;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'hDEADBEEF;
    tick();
    we[0] = 1'b0; addr[0] = 32'h10; wdata[0] = $urandom;
    mem_m[0][4] = 32'hDEADBEEF;
    for (int c = 1; c <= 8; c++) begin
      exp_ack = (c == 3 || c == 6);
      checks++;
      if (ack[0] !== exp_ack) begin
        errors++;
        $display("FAIL b2b_ack cycle T+%0d: got %b want %b", c, ack[0], exp_ack);
      end
      if (c <= 5) begin
        checks++;
        if (ready[0] !== (c == 3)) begin
          errors++;
          $display("FAIL b2b_ready cycle T+%0d: got %b want %b", c, ready[0], (c == 3));
        end
      end
      if (c == 6) begin
        checks++;
        if (rdata[0] !== 32'hDEADBEEF || err[0] !== 1'b0) begin
          errors++;
          $display("FAIL b2b_rdata: got %h err %b want deadbeef err 0", rdata[0], err[0]);
        end
      end
      if (c == 4) req[0] = 1'b0;
      tick();
    end
    rd_m[0] = 32'hDEADBEEF;
  endtask

  // Three loads on consecutive cycles through the single-cycle instance.
  task automatic test_lat1_burst();
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k < 2) addr[1] = 32'((k + 1) * 4);
      else       req[1] = 1'b0;
      checks++;
      if (ack[1] !== 1'b1 || rdata[1] !== mem_m[1][k]) begin
        errors++;
        $display("FAIL burst_load%0d: got ack=%b rd=%h want 1 %h", k, ack[1], rdata[1], mem_m[1][k]);
      end
    end
    rd_m[1] = mem_m[1][2];
    tick();
    checks++;
    if (ack[1] !== 1'b0) begin
      errors++;
      $display("FAIL burst_end: got ack=%b want 0", ack[1]);
    end
  endtask

  // Reset in the first waiting cycle drops the store.
  task automatic test_reset_mid();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h12345678;
    tick();
    req[0] = 1'b0;
    rst_n = 1'b0;
    #2;
    checks++;
    if (ready[0] !== 1'b1 || ack[0] !== 1'b0 || rdata[0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_state: got rdy=%b ack=%b rd=%h want 1 0 0", ready[0], ack[0], rdata[0]);
    end
    rst_n = 1'b1;
    rd_m[0] = '0;
    rd_m[1] = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (ack[0] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_ack cycle %0d: got %b want 0", c, ack[0]);
      end
    end
    single_txn(0, 1'b0, 32'h20, 32'h0);
  endtask

  task automatic test_addr_edges();
    for (int i = 0; i < 2; i++) begin
      single_txn(i, 1'b1, 32'h13, 32'hA5A5_0013);
      single_txn(i, 1'b0, 32'h10, 32'h0);
      single_txn(i, 1'b1, 32'(4 * DEPTH), 32'h5A5A_0040);
      single_txn(i, 1'b0, 32'h0, 32'h0);
      single_txn(i, 1'b0, 32'h13, 32'h0);
      single_txn(i, 1'b0, 32'(4 * DEPTH), 32'h0);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      single_txn(int'($urandom_range(0, 1)), 1'($urandom), 32'($urandom_range(0, 95)), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_fill();
    test_back_to_back();
    test_lat1_burst();
    test_reset_mid();
    test_addr_edges();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
